// File: rtl/npc_wb_pkg.sv
// Writeback stage shared types.
// Load-type encodings and link offset.
package npc_wb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_e;

  localparam logic [31:0] LINK_OFS = 32'd4;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute and load result handshakes
// feeding the writeback stage.
interface writeback_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  ex_valid;
  logic                  ex_ready;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0] ex_data;
  logic [31:0]           ex_pc;
  logic                  ex_jal;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [31:0]           mem_rdata;
  logic [2:0]            mem_funct3;
  logic [1:0]            mem_addr_lo;

  modport master (
    output ex_valid, ex_rd, ex_data,
    output ex_pc, ex_jal,
    output mem_valid, mem_rd, mem_rdata,
    output mem_funct3, mem_addr_lo,
    input  ex_ready, mem_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    input  ex_pc, ex_jal,
    input  mem_valid, mem_rd, mem_rdata,
    input  mem_funct3, mem_addr_lo,
    output ex_ready, mem_ready
  );

endinterface

// File: rtl/load_align.sv
// Load byte/half extraction and
// sign/zero extension.
module load_align
  import npc_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select lane, then extend by load type.
  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = rdata[{addr_lo[1], 4'b0000} +: 16];
    data = '0;
    unique case (load_e'(funct3))
      LB:      data = {{24{b[7]}}, b};
      LH:      data = {{16{h[15]}}, h};
      LW:      data = rdata;
      LBU:     data = {24'd0, b};
      LHU:     data = {16'd0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one output slot,
// load-first arbitration, retire count.
module writeback_stage
  import npc_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_stage_if.slave      bus,
  input  logic                  wb_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [63:0]           retire_cnt
);

  logic                  slot_v;
  logic [ADDR_WIDTH-1:0] slot_rd;
  logic [DATA_WIDTH-1:0] slot_d;

  logic                  free;
  logic                  take_mem;
  logic                  take_ex;
  logic [31:0]           ld_data;
  logic [DATA_WIDTH-1:0] ex_wd;
  logic [DATA_WIDTH-1:0] mem_wd;

  load_align u_align (
    .rdata   (bus.mem_rdata),
    .funct3  (bus.mem_funct3),
    .addr_lo (bus.mem_addr_lo),
    .data    (ld_data)
  );

  // Arbitration and write data selection.
  always_comb begin
    free          = !slot_v || !wb_stall;
    bus.mem_ready = !rst && free;
    bus.ex_ready  = !rst && free &&
                    !bus.mem_valid;
    take_mem      = bus.mem_ready &&
                    bus.mem_valid;
    take_ex       = bus.ex_ready &&
                    bus.ex_valid;
    ex_wd         = bus.ex_jal ?
      DATA_WIDTH'(bus.ex_pc + LINK_OFS) :
      bus.ex_data;
    if (bus.ex_rd == '0) ex_wd = '0;
    mem_wd        = DATA_WIDTH'(ld_data);
    if (bus.mem_rd == '0) mem_wd = '0;
  end

  // Output slot: replace, drain or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v  <= 1'b0;
      slot_rd <= '0;
      slot_d  <= '0;
    end else if (take_mem) begin
      slot_v  <= 1'b1;
      slot_rd <= bus.mem_rd;
      slot_d  <= mem_wd;
    end else if (take_ex) begin
      slot_v  <= 1'b1;
      slot_rd <= bus.ex_rd;
      slot_d  <= ex_wd;
    end else if (free) begin
      slot_v  <= 1'b0;
    end
  end

  assign rf_wen   = slot_v &&
                    (slot_rd != '0) &&
                    !wb_stall;
  assign rf_waddr = slot_rd;
  assign rf_wdata = slot_d;

  // Count every presented write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retire_cnt <= '0;
    else if (rf_wen) retire_cnt <= retire_cnt + 64'd1;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ex_valid  input  1  execute result offered.
REQ-006 ex_ready  output  1  execute result accepted this cycle when high with ex_valid.
REQ-007 ex_rd, ex_data, ex_pc, ex_jal  input  ADDR_WIDTH/DATA_WIDTH/32/1  destination, ALU result, instruction pc, jal/jalr link select.
REQ-008 mem_valid  input  1  load result offered.
REQ-009 mem_ready  output  1  load result accepted this cycle when high with mem_valid.
REQ-010 mem_rd, mem_rdata, mem_funct3, mem_addr_lo  input  ADDR_WIDTH/32/3/2  destination, raw aligned word, load type, byte offset.
REQ-011 wb_stall  input  1  hold request from the simulation harness; freezes the output register.
REQ-012 rf_wen, rf_waddr, rf_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  register file write port.
REQ-013 retire_cnt  output  64  count of writebacks presented to the register file.

Function
REQ-014 The block SHALL hold one output slot (valid, waddr, wdata) driving rf_wen/rf_waddr/rf_wdata directly from flops.
REQ-015 Slot is free when slot invalid, or valid and wb_stall low (drains this edge).
REQ-016 When slot free and mem_valid high, mem_ready SHALL be 1 and the load SHALL be captured; ex_ready SHALL be 0 (load has priority).
REQ-017 When slot free and mem_valid low, ex_ready SHALL be 1; mem_ready SHALL be 1 (idle accept).
REQ-018 When slot not free, ex_ready and mem_ready SHALL be 0 and the slot SHALL hold its contents unchanged.
REQ-019 Latency: a transaction accepted at edge N SHALL appear with rf_wen=1 in the cycle after edge N; one writeback per cycle maximum.
REQ-020 Execute data SHALL be ex_pc+4 (mod 2^32) when ex_jal=1, else ex_data.
REQ-021 Load data by mem_funct3: 000 lb sign-extend byte, 001 lh sign-extend half, 010 lw word, 100 lbu zero-extend byte, 101 lhu zero-extend half; byte at bits [8*mem_addr_lo +: 8], half at bits [16*mem_addr_lo[1] +: 16].
REQ-022 Unsupported mem_funct3 (011,110,111) SHALL write zero data.
REQ-023 Destination 0 SHALL be accepted and consume the slot but SHALL present rf_wen=0 and rf_wdata=0.
REQ-024 rf_wen SHALL be 1 only while slot valid, destination nonzero, and wb_stall low; during stall rf_wen=0 with waddr/wdata held.
REQ-025 Slot SHALL clear when it drains with no new acceptance in the same edge; drain and accept in the same edge SHALL replace the slot.
REQ-026 retire_cnt SHALL increment by 1 on every edge where rf_wen=1; wraps 2^64-1 to 0.

Reset
REQ-027 While rst high: slot invalid, rf_wen=0, rf_waddr=0, rf_wdata=0, retire_cnt=0; ex_ready=0, mem_ready=0.
REQ-028 rst asserted mid-transaction SHALL discard the slot contents; no write is issued after reset release until a new acceptance.
REQ-029 First acceptance possible on the first posedge clk after rst deasserts.

Structure
REQ-030 Package npc_wb_pkg SHALL hold the load-type enum (LB, LH, LW, LBU, LHU) and the link offset constant 4.
REQ-031 Load extraction/extension SHALL be a combinational sub-module load_align (rdata, funct3, addr_lo -> data).
REQ-032 Slot, arbitration and counter SHALL live in writeback_stage.

Verification
REQ-033 ex_valid, ex_rd=5, ex_data=0x1234, ex_jal=0 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, retire_cnt=1.
REQ-034 ex_jal=1, ex_pc=0x80000010, ex_rd=1 -> wdata=0x80000014; ex_rd=0 -> rf_wen=0, retire_cnt unchanged.
REQ-035 mem_rdata=0x80FF7F01, lb addr_lo=3 -> 0xFFFFFF80; lbu addr_lo=1 -> 0x0000007F; lh addr_lo=2 -> 0xFFFF80FF; lhu addr_lo=0 -> 0x00007F01.
REQ-036 ex_valid and mem_valid both high, slot empty -> mem_ready=1, ex_ready=0; load written first, execute written one cycle later.
REQ-037 wb_stall high 3 cycles with slot valid -> rf_wen=0, outputs held, both readies 0; stall release -> single write, retire_cnt +1.
REQ-038 rst pulsed while slot holds rd=7 -> rf_wen=0 and no write to 7 after release; retire_cnt=0.
